uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for 8N1-style asynchronous frames on a single `rxd` line; the receive-side counterpart of the team's serial transmitter. It oversamples the line against the system clock, rejects start-bit glitches, assembles bits LSB-first, checks the stop bit and presents each byte with a one-cycle `valid` strobe. It sits between the board-level RX pin and any byte-consuming logic (display, register file, loopback test).

## Interface
- `CLKS_PER_BIT`, 16: system clocks per serial bit; even, ≥4.
- `DATA_BITS`, 8: data bits per frame; 5–8.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idle high.
- `data`  out  DATA_BITS  last correctly framed byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse: `data` updated this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high whenever the state is not IDLE.
- `parity_err`  out  1  present only with `UART_RX_PARITY_EN`; one-cycle pulse.

## Operation
- Two-flop synchronizer on `rxd`; both flops reset to 1. All decisions use the synchronized bit `rs`.
- States: IDLE, START, DATA, PARITY (macro only), STOP. Bit counter `cnt` counts 0..CLKS_PER_BIT-1; index `idx` counts 0..DATA_BITS-1.
- IDLE: if `rs`=0, go to START with `cnt`=0. The trigger is level, not edge.
- START: in the cycle with `cnt`=CLKS_PER_BIT/2-1, sample `rs`:
  - 1: glitch; return to IDLE with no output.
  - 0: go to DATA with `cnt`=0 and `idx`=0.
- DATA: in the cycle with `cnt`=CLKS_PER_BIT-1, shift `rs` into the MSB of the shift register (right shift, LSB-first on the line).
  - After `idx`=DATA_BITS-1, go to PARITY if the macro is defined, otherwise STOP.
- STOP: in the cycle with `cnt`=CLKS_PER_BIT-1, sample `rs`:
  - 1: load `data` from the shift register and pulse `valid`.
  - 0: pulse `frame_err`; `data` is unchanged.
  - Either way, go to IDLE on the next edge.
- A line held low therefore produces a `frame_err` once per frame period. This is required behaviour.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE, `cnt`=0, `idx`=0.
- Reset mid-frame abandons the frame: no `valid` or error pulse, and `busy`=0 in the cycle after the reset edge.
- Latency: let t0 be the edge where the first synchronizer flop captures the start-bit 0.
  - `valid` or `frame_err` is high in cycle t0 + 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT.
  - Add CLKS_PER_BIT when parity is enabled.
- Back-to-back frames: the stop bit is sampled mid-bit, so IDLE is reached about half a bit early. A start bit immediately after a one-bit stop must be received.
- No backpressure: a consumer that misses the `valid` pulse loses the byte.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state samples one extra bit, even parity.
  - On mismatch: `parity_err` pulses in the STOP decision cycle, `valid` is suppressed and `data` is held.
  - A stop bit of 0 still gives `frame_err`, which takes priority over `parity_err`.
- Undefined: no PARITY state and no `parity_err` port; frame = start + DATA_BITS + stop.

## Structure
- Shared package/header `uart_defs`: state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit), default CLKS_PER_BIT and DATA_BITS. The transmitter uses the same header.
- One sub-module, `bit_timer`:
  - Parameterized counter with `clr` input and `half`/`full` outputs.
  - Used for START (`half`) and DATA/PARITY/STOP (`full`).

## Test plan
- CLKS_PER_BIT=16; send 0xA5 -> `data`=0xA5 with `valid` high for exactly one cycle at t0+2+8+144, and `busy` low the cycle after.
- 5-cycle low pulse on an idle line -> no `valid`/`frame_err`; `busy` high for at most 10 cycles, then IDLE.
- Send 0xA5, then 0x3C with stop bit 0 -> `frame_err` pulse; `data` stays 0xA5.
- Send 0x00 and 0xFF back-to-back with a one-bit stop -> two `valid` pulses, with `data` 0x00 then 0xFF.
- Assert `rst` during data bit 4 of 0x77 -> `busy`=0 next cycle, no pulses; a following 0x5A is received correctly.
- With `UART_RX_PARITY_EN`, send 0x01 with parity bit 0 -> `parity_err` pulse, no `valid`, `data` unchanged; with parity bit 1 -> `valid`, `data`=0x01.

Source files
------------

// File: rtl/uart_defs.sv
// ============================================================================
//  Module      : uart_defs (package)
//  Description : Shared definitions for the UART receiver and transmitter:
//                3-bit state encodings and default frame timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_defs;

  // Default timing: system clocks per serial bit, and data bits per frame
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  // Receiver/transmitter state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// ============================================================================
//  Module      : bit_timer
//  Description : Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1,
//                flags the half-bit point and the end of a bit period, and
//                restarts from zero whenever clr is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half,
  output logic full
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  // Counter: cleared on request, wraps at the end of each bit period
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (full) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign full = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling serial receiver for start + DATA_BITS (+ even
//                parity) + stop frames. Rejects start-bit glitches, checks
//                the stop bit and strobes each good byte with a one-cycle
//                valid pulse.
//                Optional feature macro: UART_RX_PARITY_EN (adds even parity
//                bit, PARITY state and the parity_err output).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  logic                 sync1;
  logic                 rs;
  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 timer_clr;
  logic                 half;
  logic                 full;
  logic                 last_bit;
  logic                 bit_sample;
  logic                 stop_sample;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 par_sample;
  logic                 par_ok;
`endif

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .half (half),
    .full (full)
  );

  // Two-flop synchronizer; idle-high reset so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      sync1 <= rxd;
      rs    <= sync1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign last_bit = (idx == IDX_W'(DATA_BITS - 1));

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!rs) next_state = ST_START;
      ST_START: if (half) next_state = rs ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (full && last_bit) next_state = ST_PARITY;
      ST_PARITY: if (full) next_state = ST_STOP;
`else
      ST_DATA:   if (full && last_bit) next_state = ST_STOP;
`endif
      ST_STOP:  if (full) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: the timer restarts on every state change and idles at zero
  always_comb begin
    busy        = (state != ST_IDLE);
    timer_clr   = (state == ST_IDLE) || (next_state != state);
    bit_sample  = (state == ST_DATA) && full;
    stop_sample = (state == ST_STOP) && full;
`ifdef UART_RX_PARITY_EN
    par_sample  = (state == ST_PARITY) && full;
    par_ok      = ~(^shreg ^ par_bit);
`endif
  end

  // Datapath: shift register, bit index and registered result strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      shreg      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      if (par_sample) par_bit <= rs;
`endif
      if (state != ST_DATA) begin
        idx <= '0;
      end else if (full) begin
        idx <= idx + 1'b1;
      end
      if (bit_sample) begin
        shreg <= {rs, shreg[DATA_BITS-1:1]};
      end
      if (stop_sample) begin
        // A bad stop bit outranks a parity mismatch
        if (!rs) begin
          frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (!par_ok) begin
          parity_err <= 1'b1;
`endif
        end else begin
          data  <= shreg;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (CLKS_PER_BIT=16,
//                DATA_BITS=8). Parity cases apply when UART_RX_PARITY_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + (DB + 2) * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  logic          par_flip = 1'b0;
  int            pcnt = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  // Monitor state
  int         vcnt  = 0;
  int         vcyc  = 0;
  logic [7:0] vlast = 8'h00;
  logic [7:0] vprev = 8'h00;
  int         fcnt  = 0;
  int         fcyc  = 0;
  int         bcnt  = 0;
  int         both  = 0;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle number: value equals the index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Record output pulses mid-cycle
  always @(negedge clk) begin
    if (valid) begin
      vcnt  <= vcnt + 1;
      vcyc  <= cyc;
      vprev <= vlast;
      vlast <= data;
    end
    if (frame_err) begin
      fcnt <= fcnt + 1;
      fcyc <= cyc;
    end
    if (busy) bcnt <= bcnt + 1;
    if (valid && frame_err) both <= both + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pcnt <= pcnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Drives one frame; call at #1 after a rising edge, returns likewise
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    rxd = 1'b0;
    t0  = cyc + 1;
    hold();
    for (int i = 0; i < DB; i++) begin
      rxd = b[i];
      hold();
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    hold();
`endif
    rxd = stopb;
    hold();
    rxd = 1'b1;
  endtask

  initial begin
    int v0, f0, b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Good frame 0xA5, exact latency
    v0 = vcnt;
    send_frame(8'hA5, 1'b1);
    #2;
    chk("a5_count", 32'(vcnt - v0), 32'd1);
    chk("a5_data", 32'(vlast), 32'hA5);
    chk("a5_latency", 32'(vcyc - t0), 32'(LAT));
    chk("a5_busy_after", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Start-bit glitch of 5 cycles
    v0 = vcnt; f0 = fcnt; b0 = bcnt;
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_no_valid", 32'(vcnt - v0), 32'd0);
    chk("glitch_no_ferr", 32'(fcnt - f0), 32'd0);
    chk("glitch_busy_le10", 32'(bcnt - b0 <= 10), 32'd1);
    chk("glitch_busy_seen", 32'(bcnt - b0 > 0), 32'd1);
    chk("glitch_idle", 32'(busy), 32'd0);

    // Bad stop bit on 0x3C
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b0);
    #2;
    chk("ferr_count", 32'(fcnt - f0), 32'd1);
    chk("ferr_latency", 32'(fcyc - t0), 32'(LAT));
    chk("ferr_no_valid", 32'(vcnt - v0), 32'd0);
    chk("ferr_data_held", 32'(data), 32'hA5);
    repeat (40) @(posedge clk);
    #1;
    chk("ferr_recover_idle", 32'(busy), 32'd0);

    // Back-to-back 0x00 then 0xFF with a one-bit stop
    v0 = vcnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    #2;
    chk("b2b_count", 32'(vcnt - v0), 32'd2);
    chk("b2b_first", 32'(vprev), 32'h00);
    chk("b2b_second", 32'(vlast), 32'hFF);
    repeat (4) @(posedge clk);
    #1;

    // Reset during data bit 4 of 0x77
    v0 = vcnt; f0 = fcnt;
    rxd = 1'b0;
    hold();
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b1 : 1'b1;
      if (i == 3) rxd = 1'b0;
      hold();
    end
    rxd = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    chk("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy_low", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("rst_no_valid", 32'(vcnt - v0), 32'd0);
    chk("rst_no_ferr", 32'(fcnt - f0), 32'd0);
    chk("rst_data_cleared", 32'(data), 32'h00);
    send_frame(8'h5A, 1'b1);
    #2;
    chk("after_rst_count", 32'(vcnt - v0), 32'd1);
    chk("after_rst_data", 32'(vlast), 32'h5A);
    repeat (4) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    // Wrong then right parity on 0x01
    v0 = vcnt; f0 = pcnt;
    par_flip = 1'b1;
    send_frame(8'h01, 1'b1);
    #2;
    chk("par_err_count", 32'(pcnt - f0), 32'd1);
    chk("par_err_no_valid", 32'(vcnt - v0), 32'd0);
    chk("par_err_data_held", 32'(data), 32'h5A);
    par_flip = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h01, 1'b1);
    #2;
    chk("par_ok_valid", 32'(vcnt - v0), 32'd1);
    chk("par_ok_data", 32'(data), 32'h01);
    chk("par_ok_no_err", 32'(pcnt - f0), 32'd1);
`endif

    chk("never_valid_and_ferr", 32'(both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
